operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Producer side of the execute-stage operand interface. Reads a 32x32 register file, registers op1/op2 into the ID/EX pipeline register and presents them to execute with a valid/ready handshake.
- Accepts execute's 64-bit result and zero flag back as writeback: the low word goes to a GPR, or the full result goes to HI/LO for mult/div.
- A per-register scoreboard stalls issue on RAW hazards.

Parameters:
DATA_W, 32, GPR/operand width
REG_ADDR_W, 5, register address width
NUM_REGS, 32, register count (r0 hardwired zero)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle when in_valid & in_ready
rs_addr  input  5  source register for op1
rt_addr  input  5  source register for op2
rd_addr  input  5  destination GPR
imm  input  32  sign-extended immediate
use_imm  input  1  op2 = imm, rt not read
wr_hilo  input  1  instruction writes HI/LO instead of rd
ex_valid  output  1  op1/op2 valid toward execute
ex_ready  input  1  execute consumes operands
op1  output  32  operand 1
op2  output  32  operand 2
ex_rd  output  5  destination tag travelling with operands
ex_hilo  output  1  HI/LO tag travelling with operands
wb_valid  input  1  writeback from execute
wb_rd  input  5  writeback destination
wb_hilo  input  1  writeback targets HI/LO
wb_result  input  64  execute result
wb_zero  input  1  execute zeroFlag
hi  output  32  HI register
lo  output  32  LO register
zero_q  output  1  last written-back zeroFlag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all GPRs 0, HI=LO=0, zero_q=0, scoreboard clear, ex_valid=0, op1=op2=0, ex_rd=0, ex_hilo=0.
- Writeback, every edge with wb_valid=1:
  - wb_hilo=1: HI<=wb_result[63:32], LO<=wb_result[31:0]; no GPR written.
  - wb_hilo=0 and wb_rd!=0: GPR[wb_rd]<=wb_result[31:0].
  - wb_rd=0 with wb_hilo=0: write discarded.
  - zero_q<=wb_zero in all cases.
- Read bypass: a read of a register written by writeback in the same cycle returns wb_result[31:0]. Reads of r0 always return 0.
- Scoreboard: one pending bit per GPR, plus one for HI/LO.
  - Set on issue of rd (if rd!=0 and !wr_hilo), or of HI/LO (if wr_hilo).
  - Cleared on matching writeback.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard:
  - hz = (pend[rs] & !clr[rs]) | (!use_imm & pend[rt] & !clr[rt]), where clr is this cycle's writeback clear.
  - HI/LO readers are outside this block's scope; pend_hilo only blocks another wr_hilo issue (WAW).
- Handshake: in_ready = !hz & (!ex_valid | ex_ready). Combinational; must not depend on in_valid.
- Pipeline register:
  - On accept: load op1, op2 (imm if use_imm), ex_rd, ex_hilo; ex_valid<=1.
  - Else if ex_ready: ex_valid<=0.
  - Outputs held stable while ex_valid & !ex_ready.
- Latency: accept to ex_valid is 1 cycle. Full throughput (1 per cycle) with no hazards.
- Reset mid-operation: ex_valid drops next edge, pending bits clear, and any in-flight writeback in that cycle is ignored (reset has priority over all writes).

Decomposition:
- mips_pkg holds:
  - constants DATA_W, REG_ADDR_W, NUM_REGS
  - typedefs word_t (32b), dword_t (64b), reg_addr_t (5b)
  - struct id_ex_t {op1, op2, rd, hilo}, shared with execute
- Sub-module regfile_2r1w: 2 async read ports, 1 write port, r0 zero, write-first bypass.
- Scoreboard and pipeline register stay in operand_fetch.

Test Plan:
- Reset then write r2=2 via wb; issue rs=2, rt=2 -> next cycle ex_valid=1, op1=2, op2=2, in_ready stays 1.
- Issue rd=3, then immediately rs=3 -> in_ready=0 until wb_rd=3, wb_result=64'h5 arrives. Same cycle in_ready=1 (bypass), op1=5 next cycle.
- wb_hilo=1, wb_result=64'h00000001_00000004, wb_zero=0 -> hi=1, lo=4, zero_q=0. wb_result=0, wb_zero=1 -> zero_q=1.
- ex_ready=0 for 3 cycles with ex_valid=1 -> op1/op2 unchanged and in_ready=0. Release -> next queued instruction loads in 1 cycle.
- Write wb_rd=0, value 7, then read rs=0 -> op1=0. use_imm=1, imm=32'hFFFFFFFE with rt pending -> no stall, op2=FFFFFFFE.
- Assert reset while ex_valid=1 and r3 pending -> next cycle ex_valid=0, all pending bits clear, r3 issue no longer stalls.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the operand-fetch / execute boundary.
// Holds widths, word types and the ID/EX bundle passed to execute.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [2*DATA_W-1:0]   dword_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    word_t     op1;
    word_t     op2;
    reg_addr_t rd;
    logic      hilo;
  } id_ex_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, execute and writeback signals of operand_fetch.
// slave: the operand_fetch side; master: decode/execute side.
interface operand_fetch_if;
  import mips_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  reg_addr_t rd_addr;
  word_t     imm;
  logic      use_imm;
  logic      wr_hilo;

  logic      ex_valid;
  logic      ex_ready;
  word_t     op1;
  word_t     op2;
  reg_addr_t ex_rd;
  logic      ex_hilo;

  logic      wb_valid;
  reg_addr_t wb_rd;
  logic      wb_hilo;
  dword_t    wb_result;
  logic      wb_zero;

  word_t     hi;
  word_t     lo;
  logic      zero_q;

  modport slave (
    input  in_valid, rs_addr, rt_addr, rd_addr,
    input  imm, use_imm, wr_hilo, ex_ready,
    input  wb_valid, wb_rd, wb_hilo, wb_result, wb_zero,
    output in_ready, ex_valid, op1, op2, ex_rd, ex_hilo,
    output hi, lo, zero_q
  );

  modport master (
    output in_valid, rs_addr, rt_addr, rd_addr,
    output imm, use_imm, wr_hilo, ex_ready,
    output wb_valid, wb_rd, wb_hilo, wb_result, wb_zero,
    input  in_ready, ex_valid, op1, op2, ex_rd, ex_hilo,
    input  hi, lo, zero_q
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 32x32 GPR file: two async read ports, one write port.
// Ports: ra1/ra2 -> rd1/rd2, we/wa/wd write; r0 reads 0, write-first.
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output word_t     rd1,
  output word_t     rd2,
  input  logic      we,
  input  reg_addr_t wa,
  input  word_t     wd
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  logic  wr_en;

  assign wr_en = we && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Same-cycle writes are forwarded so readers never see stale data.
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (wr_en && wa == ra1) rd1 = wd;
    if (wr_en && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, RAW scoreboard, ID/EX register, writeback.
// Ports: clk, reset, bus (operand_fetch_if.slave).
module operand_fetch
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  operand_fetch_if.slave  bus
);

  word_t rd1, rd2;
  logic  gpr_we;

  assign gpr_we = bus.wb_valid && !bus.wb_hilo;

  regfile_2r1w u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (bus.rs_addr),
    .ra2   (bus.rt_addr),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (gpr_we),
    .wa    (bus.wb_rd),
    .wd    (bus.wb_result[DATA_W-1:0])
  );

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] clr, set;
  logic                hpend_q, hpend_d;
  logic                hclr;
  id_ex_t              pipe_q, pipe_d;
  logic                valid_q, valid_d;
  word_t               hi_q, hi_d;
  word_t               lo_q, lo_d;
  logic                zero_q, zero_d;
  logic                hz, ready, accept;

  always_comb begin
    clr = '0;
    if (gpr_we) clr[bus.wb_rd] = 1'b1;
    clr[0] = 1'b0;
    hclr = bus.wb_valid && bus.wb_hilo;

    // A writeback landing this cycle resolves the hazard via bypass.
    hz = (pend_q[bus.rs_addr] && !clr[bus.rs_addr])
       || (!bus.use_imm && pend_q[bus.rt_addr]
           && !clr[bus.rt_addr])
       || (bus.wr_hilo && hpend_q && !hclr);
    ready  = !hz && (!valid_q || bus.ex_ready);
    accept = bus.in_valid && ready;

    set = '0;
    if (accept && !bus.wr_hilo) set[bus.rd_addr] = 1'b1;
    set[0] = 1'b0;
    pend_d  = (pend_q & ~clr) | set;
    hpend_d = (hpend_q && !hclr) || (accept && bus.wr_hilo);

    pipe_d  = pipe_q;
    valid_d = valid_q;
    if (accept) begin
      pipe_d.op1  = rd1;
      pipe_d.op2  = bus.use_imm ? bus.imm : rd2;
      pipe_d.rd   = bus.rd_addr;
      pipe_d.hilo = bus.wr_hilo;
      valid_d     = 1'b1;
    end else if (bus.ex_ready) begin
      valid_d = 1'b0;
    end

    hi_d   = hi_q;
    lo_d   = lo_q;
    zero_d = zero_q;
    if (bus.wb_valid) begin
      zero_d = bus.wb_zero;
      if (bus.wb_hilo) begin
        hi_d = bus.wb_result[2*DATA_W-1:DATA_W];
        lo_d = bus.wb_result[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      hpend_q <= 1'b0;
      pipe_q  <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      hpend_q <= hpend_d;
      pipe_q  <= pipe_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.ex_valid = valid_q;
  assign bus.op1      = pipe_q.op1;
  assign bus.op2      = pipe_q.op2;
  assign bus.ex_rd    = pipe_q.rd;
  assign bus.ex_hilo  = pipe_q.hilo;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.zero_q   = zero_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed plus random traffic.
// Expected operands are queued on issue and checked by a monitor.
module tb_operand_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  word_t  m_gpr [NUM_REGS];
  bit     m_pend [NUM_REGS];
  bit     m_pend_hilo;
  word_t  m_hi, m_lo;
  bit     m_zero;
  id_ex_t q [$];

  function automatic void chk(string name, logic [71:0] act,
                              logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    foreach (m_gpr[i]) m_gpr[i] = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_pend_hilo = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_zero = 1'b0;
    q.delete();
  endfunction

  // True when this cycle's writeback lands in GPR a.
  function automatic bit wb_hits(reg_addr_t a);
    return bus.wb_valid && !bus.wb_hilo && bus.wb_rd == a && a != 0;
  endfunction

  function automatic word_t read_reg(reg_addr_t a);
    if (a == 0) return '0;
    if (wb_hits(a)) return bus.wb_result[31:0];
    return m_gpr[a];
  endfunction

  task automatic set_idle();
    bus.in_valid = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.rd_addr = 0; bus.imm = 0; bus.use_imm = 0;
    bus.wr_hilo = 0; bus.ex_ready = 1; bus.wb_valid = 0;
    bus.wb_rd = 0; bus.wb_hilo = 0; bus.wb_result = 0;
    bus.wb_zero = 0;
  endtask

  task automatic issue(int rs, int rt, int rd);
    bus.in_valid = 1;
    bus.rs_addr = reg_addr_t'(rs);
    bus.rt_addr = reg_addr_t'(rt);
    bus.rd_addr = reg_addr_t'(rd);
  endtask

  task automatic wb(int rd, logic [63:0] res);
    bus.wb_valid = 1;
    bus.wb_hilo = 0;
    bus.wb_rd = reg_addr_t'(rd);
    bus.wb_result = res;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    bit hz, rdy, acc;
    id_ex_t e;
    #1;
    hz = (m_pend[bus.rs_addr] && !wb_hits(bus.rs_addr))
      || (!bus.use_imm && m_pend[bus.rt_addr]
          && !wb_hits(bus.rt_addr))
      || (bus.wr_hilo && m_pend_hilo
          && !(bus.wb_valid && bus.wb_hilo));
    rdy = !hz && (q.size() == 0 || bus.ex_ready);
    acc = bus.in_valid && rdy;
    e.op1 = read_reg(bus.rs_addr);
    e.op2 = bus.use_imm ? bus.imm : read_reg(bus.rt_addr);
    e.rd = bus.rd_addr;
    e.hilo = bus.wr_hilo;
    chk("in_ready", 72'(bus.in_ready), 72'(rdy));
    chk("hi", 72'(bus.hi), 72'(m_hi));
    chk("lo", 72'(bus.lo), 72'(m_lo));
    chk("zero_q", 72'(bus.zero_q), 72'(m_zero));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (bus.wb_valid) begin
        m_zero = bus.wb_zero;
        if (bus.wb_hilo) begin
          m_hi = bus.wb_result[63:32];
          m_lo = bus.wb_result[31:0];
          m_pend_hilo = 1'b0;
        end else if (bus.wb_rd != 0) begin
          m_gpr[bus.wb_rd] = bus.wb_result[31:0];
          m_pend[bus.wb_rd] = 1'b0;
        end
      end
      if (acc) begin
        q.push_back(e);
        if (bus.wr_hilo) m_pend_hilo = 1'b1;
        else if (bus.rd_addr != 0) m_pend[bus.rd_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: whatever is held toward execute must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        chk("ex_valid", 72'(bus.ex_valid), 72'(q.size() != 0));
        if (bus.ex_valid && q.size() != 0) begin
          chk("op1", 72'(bus.op1), 72'(q[0].op1));
          chk("op2", 72'(bus.op2), 72'(q[0].op2));
          chk("ex_rd", 72'(bus.ex_rd), 72'(q[0].rd));
          chk("ex_hilo", 72'(bus.ex_hilo), 72'(q[0].hilo));
          if (bus.ex_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    set_idle();
    reset = 1;
    repeat (2) @(negedge clk);
    model_reset();
    chk_en = 1;
    step();
    reset = 0;

    wb(2, 64'h2); step(); set_idle();
    issue(2, 2, 5); step();
    wb(5, 64'h55); bus.in_valid = 0; step(); set_idle();

    issue(0, 0, 3); step();
    issue(3, 0, 4); step(); step();
    wb(3, 64'h5); step(); set_idle(); step();
    wb(4, 64'h9); step(); set_idle();

    bus.wb_valid = 1; bus.wb_hilo = 1;
    bus.wb_result = 64'h00000001_00000004; bus.wb_zero = 0; step();
    bus.wb_result = 64'h0; bus.wb_zero = 1; step(); set_idle();
    step();

    issue(2, 2, 0); bus.ex_ready = 0; step();
    issue(2, 0, 0); bus.use_imm = 1; bus.imm = 32'h1234;
    repeat (3) step();
    bus.ex_ready = 1; step(); set_idle(); step();

    wb(0, 64'h7); step(); set_idle();
    issue(0, 0, 0); step(); set_idle();

    issue(0, 0, 6); step();
    issue(0, 6, 0); bus.use_imm = 1; bus.imm = 32'hFFFFFFFE; step();
    set_idle(); wb(6, 64'h66); step(); set_idle();

    issue(0, 0, 3); bus.ex_ready = 0; step();
    set_idle(); bus.ex_ready = 0; reset = 1;
    wb(7, 64'hDEAD); step(); set_idle(); reset = 0;
    issue(3, 7, 0); step(); set_idle(); step();

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.rs_addr = reg_addr_t'($urandom_range(0, 7));
      bus.rt_addr = reg_addr_t'($urandom_range(0, 7));
      bus.rd_addr = reg_addr_t'($urandom_range(0, 7));
      bus.imm = $urandom;
      bus.use_imm = $urandom_range(0, 3) == 0;
      bus.wr_hilo = $urandom_range(0, 7) == 0;
      bus.ex_ready = $urandom_range(0, 3) != 0;
      bus.wb_valid = $urandom_range(0, 1) != 0;
      bus.wb_rd = reg_addr_t'($urandom_range(0, 7));
      bus.wb_hilo = $urandom_range(0, 5) == 0;
      bus.wb_result = {$urandom, $urandom};
      bus.wb_zero = $urandom_range(0, 1) != 0;
      step();
    end
    reset = 0;
    set_idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
